// File: rtl/morph_pkg.sv
// Shared definitions for the binary-morphology frame controller:
// filter modes, controller states and the morphology pipeline depth.
package morph_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_ERODE  = 2'd1,
        MODE_DILATE = 2'd2,
        MODE_OPEN   = 2'd3
    } morph_mode_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } ctrl_state_e;

    // Clocks from a pixel entering the erosion/dilation chain to erosion_de.
    localparam int MORPH_LAT = 2;

endpackage

// File: rtl/morph_ctrl_if.sv
// Binary-stream, mode-request and status signals between the video/host side
// (master) and the morphology controller (slave).
interface morph_ctrl_if #(
    parameter int CW = 12
) ();

    logic          bin_vs;
    logic          bin_de;
    logic          cfg_valid;
    logic [1:0]    cfg_mode;
    logic          cfg_ready;
    logic [1:0]    act_mode;
    logic          border_mask;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] row_cnt;
    logic          frame_done;
    logic          err_clr;
    logic          size_err;

    modport master (
        output bin_vs, bin_de, cfg_valid, cfg_mode, err_clr,
        input  cfg_ready, act_mode, border_mask, col_cnt, row_cnt, frame_done, size_err
    );

    modport slave (
        input  bin_vs, bin_de, cfg_valid, cfg_mode, err_clr,
        output cfg_ready, act_mode, border_mask, col_cnt, row_cnt, frame_done, size_err
    );

endinterface

// File: rtl/sync_delay.sv
// Depth-N, W-bit shift register with asynchronous reset; used for edge
// detection of the sync signals and for aligning border_mask with the filter.
module sync_delay #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_pipe [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this pipe is a handful of control flops, so every stage is
            // reset; a wide data memory would normally be left unreset.
            for (int i = 0; i < N; i++) r_pipe[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its
            // predecessor's pre-edge value, independent of statement order.
            r_pipe[0] <= i_d;
            for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[N-1];

endmodule

// File: rtl/morph_ctrl.sv
// Frame-synchronous controller for the 3x3 binary morphology chain: shadowed
// mode requests, pixel/line tracking, border mask and frame-size checking.
module morph_ctrl
    import morph_pkg::*;
#(
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720,
    parameter int CW    = 12
) (
    input  logic        video_clk,
    input  logic        rst_n,
    morph_ctrl_if.slave bus
);

    localparam logic [CW-1:0] C_H_ACT   = CW'(H_ACT);
    localparam logic [CW-1:0] C_H_LAST  = CW'(H_ACT - 1);
    localparam logic [CW-1:0] C_V_ACT   = CW'(V_ACT);
    localparam logic [CW-1:0] C_V_LAST  = CW'(V_ACT - 1);
    localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

    ctrl_state_e   r_state, w_state_nxt;
    logic [CW-1:0] r_col, r_row;
    logic [CW-1:0] w_col_nxt, w_row_nxt, w_row_inc;
    logic          r_frame_done, r_size_err, r_pending;
    morph_mode_e   r_act_mode, r_pend_mode;
    logic [1:0]    w_sync_q;
    logic          w_vs_rise, w_de_fall, w_cfg_xfer;
    logic          w_edge, w_border, w_line_err, w_frame_err, w_frame_done;

    sync_delay #(.N(1), .W(2)) u_sync_dly (
        .clk   (video_clk),
        .rst_n (rst_n),
        .i_d   ({bus.bin_vs, bus.bin_de}),
        .o_q   (w_sync_q)
    );

    assign w_vs_rise  = bus.bin_vs & ~w_sync_q[1];
    assign w_de_fall  = ~bus.bin_de & w_sync_q[0];
    assign w_cfg_xfer = bus.cfg_valid & ~r_pending;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_row_inc    = r_row;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_line_err   = 1'b0;
        w_frame_err  = 1'b0;
        w_frame_done = 1'b0;
        w_edge       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_vs_rise) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                w_edge = bus.bin_de && (r_col == '0 || r_col == C_H_LAST ||
                                        r_row == '0 || r_row == C_V_LAST);
                if (w_de_fall) begin
                    w_row_inc    = (r_row == C_CNT_MAX) ? r_row : r_row + 1'b1;
                    w_line_err   = (r_col != C_H_ACT);
                    w_frame_done = (w_row_inc == C_V_ACT);
                    w_col_nxt    = '0;
                end else if (bus.bin_de) begin
                    w_col_nxt = (r_col == C_CNT_MAX) ? r_col : r_col + 1'b1;
                end
                w_row_nxt = w_row_inc;
                // A coincident line end is counted first; the frame clear wins.
                if (w_vs_rise) begin
                    w_frame_err = (w_row_inc != C_V_ACT);
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
            r_size_err   <= 1'b0;
            r_pending    <= 1'b0;
            r_pend_mode  <= MODE_BYPASS;
            r_act_mode   <= MODE_BYPASS;
        end else begin
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_frame_done <= w_frame_done;
            if (w_line_err || w_frame_err) r_size_err <= 1'b1;
            else if (bus.err_clr)          r_size_err <= 1'b0;
            // A request accepted on a frame-start edge waits for the next one.
            if (w_cfg_xfer) begin
                r_pend_mode <= morph_mode_e'(bus.cfg_mode);
                r_pending   <= 1'b1;
            end else if (w_vs_rise && r_pending) begin
                r_act_mode <= r_pend_mode;
                r_pending  <= 1'b0;
            end
        end
    end

    sync_delay #(.N(MORPH_LAT), .W(1)) u_border_dly (
        .clk   (video_clk),
        .rst_n (rst_n),
        .i_d   (w_edge),
        .o_q   (w_border)
    );

    assign bus.cfg_ready   = ~r_pending;
    assign bus.act_mode    = r_act_mode;
    assign bus.border_mask = w_border;
    assign bus.col_cnt     = r_col;
    assign bus.row_cnt     = r_row;
    assign bus.frame_done  = r_frame_done;
    assign bus.size_err    = r_size_err;

endmodule
